// File: rtl/fc_pkg.sv
// Shared types and defaults for the fully-connected classifier datapath.
package fc_pkg;

    localparam int FC_WORD_SIZE = 16;
    localparam int FC_INT_SLICE = 8;
    localparam int NUM_CLASSES_L2 = 10;

    typedef logic signed [FC_WORD_SIZE-1:0] score_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } argmax_state_t;

endpackage

// File: rtl/fc_argmax_seq_if.sv
// Score stream in, class result out, plus status flags.
interface fc_argmax_seq_if #(
    parameter int WORD_SIZE = 16,
    parameter int IDX_W = 4
);

    logic start;
    logic in_valid;
    logic [WORD_SIZE-1:0] in_data;
    logic in_ready;
    logic [IDX_W-1:0] result;
    logic [WORD_SIZE-1:0] max_value;
    logic result_valid;
    logic result_ack;
    logic busy;
    logic protocol_err;

    modport master (
        output start, in_valid, in_data, result_ack,
        input in_ready, result, max_value, result_valid, busy, protocol_err
    );

    modport slave (
        input start, in_valid, in_data, result_ack,
        output in_ready, result, max_value, result_valid, busy, protocol_err
    );

endinterface

// File: rtl/fc_argmax_seq.sv
// Serial argmax over the layer-2 scores with a held, acknowledged result.
module fc_argmax_seq
    import fc_pkg::*;
#(
    parameter int WORD_SIZE = FC_WORD_SIZE,
    parameter int INT_SLICE = FC_INT_SLICE,
    parameter int NUM_CLASSES = NUM_CLASSES_L2
) (
    input logic clk,
    input logic rst,
    fc_argmax_seq_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_CLASSES);

    if (NUM_CLASSES < 2 || NUM_CLASSES > 16 || INT_SLICE > WORD_SIZE) begin : g_bad_cfg
        $error("fc_argmax_seq: illegal parameter set");
    end

    argmax_state_t state, state_nx;
    logic [IDX_W-1:0] count, count_nx;
    logic [IDX_W-1:0] result_q, result_nx;
    logic signed [WORD_SIZE-1:0] max_q, max_nx;
    logic err_q, err_nx;
    logic valid_q, busy_q;
    logic accept, last;

    assign bus.in_ready = (state == COLLECT);
    assign accept = bus.in_valid && bus.in_ready;
    assign last = (count == IDX_W'(NUM_CLASSES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            result_q <= '0;
            max_q <= '0;
            err_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            result_q <= result_nx;
            max_q <= max_nx;
            err_q <= err_nx;
            valid_q <= (state_nx == HOLD);
            busy_q <= (state_nx != IDLE);
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        result_nx = result_q;
        max_nx = max_q;
        err_nx = err_q;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = COLLECT;
                    count_nx = '0;
                    err_nx = 1'b0;
                end
            end
            COLLECT: begin
                if (accept) begin
                    // beat 0 always seeds; later beats need strictly greater
                    if (count == '0 || $signed(bus.in_data) > max_q) begin
                        max_nx = bus.in_data;
                        result_nx = count;
                    end
                    if (last) begin
                        state_nx = HOLD;
                    end else begin
                        count_nx = count + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.result_ack) begin
                    if (bus.start) begin
                        state_nx = COLLECT;
                        count_nx = '0;
                        err_nx = 1'b0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        if (bus.in_valid && !bus.in_ready) begin
            err_nx = 1'b1;
        end
    end

    assign bus.result = result_q;
    assign bus.max_value = max_q;
    assign bus.result_valid = valid_q;
    assign bus.busy = busy_q;
    assign bus.protocol_err = err_q;

endmodule

// File: doc/fc_argmax_seq.md
Name: fc_argmax_seq

Overview:
- Sequential classifier stage directly downstream of the second fully-connected layer.
- Consumes the NUM_CLASSES layer-2 output scores as a serial valid/ready stream, one signed fixed-point word per beat.
- Tracks the running maximum and produces the winning class index with a hold-until-acknowledged result handshake.
- Replaces the combinational soft-max/argmax selection, so the FC datapath can be time-multiplexed.

Parameters:
- WORD_SIZE, 16: width of each score word; two's-complement fixed point.
- INT_SLICE, 8: integer bits of the score format; the remaining WORD_SIZE-INT_SLICE bits are fraction. Affects only the interpretation of max_value; comparison is plain signed.
- NUM_CLASSES, 10: number of scores per inference; legal range 2..16.
- IDX_W (localparam): $clog2(NUM_CLASSES), which is 4 at the default.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins collection of a new score vector.
- in_valid  in  1  score beat valid.
- in_data  in  WORD_SIZE  signed score for class index = beat number (0 first).
- in_ready  out  1  high only in COLLECT.
- result  out  IDX_W  winning class index.
- max_value  out  WORD_SIZE  score of the winning class.
- result_valid  out  1  high in HOLD.
- result_ack  in  1  consumer accepts result.
- busy  out  1  high in COLLECT or HOLD.
- protocol_err  out  1  sticky flag; set when in_valid is high while in_ready is low.

Behaviour:
- Reset values: state=IDLE, count=0, result=0, max_value=0, result_valid=0, in_ready=0, busy=0, protocol_err=0.
- States: IDLE, COLLECT, HOLD. Encoding comes from the shared package enum.
- IDLE to COLLECT on start. Entering COLLECT clears count and sets protocol_err=0.
- COLLECT beat accept is (in_valid && in_ready):
  - beat 0: load max_value=in_data, result=0 unconditionally;
  - beat k>0: if $signed(in_data) > $signed(max_value), load max_value=in_data, result=k;
  - ties keep the lower index (strict greater-than);
  - count increments per accepted beat; no stall on in_valid low, the block simply waits.
- On the beat with count==NUM_CLASSES-1, go to HOLD. result_valid rises the next cycle, so latency is 1 cycle after the final beat. in_ready is low in that HOLD cycle.
- HOLD: result, max_value and result_valid are stable until result_ack.
  - result_ack=1 and start=0: go to IDLE; result_valid=0 next cycle; result and max_value keep their last values.
  - result_ack=1 and start=1 in the same cycle: go directly to COLLECT (back-to-back inference).
- start while in COLLECT, or in HOLD without result_ack: ignored; no restart, no error.
- result_ack outside HOLD: ignored.
- in_valid high while in_ready low (IDLE or HOLD): the beat is dropped and protocol_err is set.
  - protocol_err stays set until the next accepted start, or until reset.
- count is IDX_W bits and never wraps: the transition to HOLD happens exactly at NUM_CLASSES-1.
- Reset asserted mid-COLLECT or mid-HOLD: immediate return to reset values; partial results are discarded.
- All outputs come directly from registers; there is no combinational input-to-output path except that in_ready is decoded from state.

Decomposition:
- Shared package fc_pkg holds:
  - WORD_SIZE and INT_SLICE defaults;
  - typedef score_t = logic signed [WORD_SIZE-1:0];
  - typedef enum argmax_state_t {IDLE, COLLECT, HOLD};
  - NUM_CLASSES_L2=10.
- Optional sub-module fc_signed_max_cmp: combinational signed greater-than compare plus the index mux. Keep it inline unless it is reused by a pooling stage.

Test Plan:
- Basic: start, then scores 0x0100,0x0300,0xFF00,0x0280,0x0050,0x0010,0x0000,0x0200,0x0100,0x0001 with in_valid every cycle -> result=1, max_value=0x0300, result_valid 1 cycle after beat 9.
- All negative with tie: all scores 0xFF80 except class 6 at 0xFFC0 and class 8 at 0xFFC0 -> result=6 (lower index wins), max_value=0xFFC0.
- Bubbles and hold: in_valid deasserted randomly between beats, winning class 9 at 0x7FFF -> result=9; result_valid held 20 cycles with no ack, values unchanged; ack -> result_valid=0 next cycle.
- Back-to-back: result_ack and start in the same HOLD cycle, then second vector with max at class 0 -> in_ready=1 next cycle; second result=0.
- Protocol error: in_valid pulse in IDLE -> protocol_err=1, count unchanged; next start -> protocol_err=0.
- Mid-op reset: rst asserted asynchronously after beat 4 -> all outputs at reset values immediately, before the next clk edge; state IDLE; new start then 10 beats -> correct result.
